// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every CPU reset domain, releases them one at a time
// with per-domain gaps, then counts run cycles. Supports a synchronous soft re-sequence.
module rst_seq_ctrl #(
  parameter int NCH      = 6,
  parameter int HOLD_CYC = 10,
  parameter int GAP_W    = 8,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   sw_rst,
  input  logic [NCH*GAP_W-1:0]   gap,
  input  logic                   halt,
  output logic [NCH-1:0]         n_rst_out,
  output logic                   ready,
  output logic [CNT_W-1:0]       run_cnt
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int CW     = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
  localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NCH - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {HOLD, REL, RUN} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [IW-1:0]          idx, idx_d;
  logic [NCH*GAP_W-1:0]   gap_sh, gap_sh_d;
  logic [NCH-1:0]         rel_d;
  logic                   ready_d;
  logic [CNT_W-1:0]       run_d;
  logic [GAP_W-1:0]       cur_gap;
  logic [NCH-1:0]         rel_mask;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign cur_gap  = gap_sh[int'(idx)*GAP_W +: GAP_W];
  assign rel_mask = NCH'(1) << idx;

  // State register: every output is a flop, so no input reaches an output combinationally
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      gap_sh    <= '0;
      n_rst_out <= '0;
      ready     <= 1'b0;
      run_cnt   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      gap_sh    <= gap_sh_d;
      n_rst_out <= rel_d;
      ready     <= ready_d;
      run_cnt   <= run_d;
    end
  end

  // Next-state logic; sw_rst overrides every state
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    gap_sh_d = gap_sh;
    rel_d    = n_rst_out;
    ready_d  = ready;
    run_d    = run_cnt;
    if (sw_rst) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rel_d   = '0;
      ready_d = 1'b0;
      run_d   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_d  = REL;
            cnt_d    = '0;
            idx_d    = '0;
            gap_sh_d = gap;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        REL: begin
          if (cnt == CW'(cur_gap)) begin
            rel_d = n_rst_out | rel_mask;
            cnt_d = '0;
            if (idx == LAST_IDX) begin
              ready_d = 1'b1;
              state_d = RUN;
            end else begin
              idx_d = idx + IW'(1);
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        RUN: begin
          if (!halt) run_d = sat_inc(run_cnt);
        end
        default: state_d = HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues expected output changes,
// a negedge monitor pops and compares whenever the outputs change.
module tb_rst_seq_ctrl;

  logic        clk = 1'b0;
  logic        n_rst, sw_rst, halt;
  logic [47:0] gap;
  logic [7:0]  gap1;
  logic [5:0]  n_rst_out;
  logic        ready;
  logic [31:0] run_cnt;
  logic [0:0]  n_rst_out1;
  logic        ready1;
  logic [3:0]  run_cnt1;

  int cyc = 0;
  int b = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [5:0]  nro;
    logic        rdy;
    logic [31:0] rc;
  } exp_t;
  exp_t q[$];

  rst_seq_ctrl dut (
    .clk(clk), .n_rst(n_rst), .sw_rst(sw_rst), .gap(gap), .halt(halt),
    .n_rst_out(n_rst_out), .ready(ready), .run_cnt(run_cnt)
  );

  rst_seq_ctrl #(.NCH(1), .HOLD_CYC(3), .GAP_W(8), .CNT_W(4)) dut1 (
    .clk(clk), .n_rst(n_rst), .sw_rst(sw_rst), .gap(gap1), .halt(halt),
    .n_rst_out(n_rst_out1), .ready(ready1), .run_cnt(run_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [5:0] m, input logic r, input logic [31:0] rc);
    exp_t e;
    e.cyc = b + k;
    e.nro = m;
    e.rdy = r;
    e.rc  = rc;
    q.push_back(e);
  endtask

  task automatic to_edge(input int k);
    while (cyc < b + k) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: any output change must match the head of the expectation queue
  initial begin
    logic [38:0] prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {n_rst_out, ready, run_cnt};
      if (cur !== prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got %0h with nothing expected (cyc %0d)", cur, cyc);
        end else begin
          e = q.pop_front();
          chk("evt_cycle", 64'(cyc), 64'(e.cyc));
          chk("evt_n_rst_out", 64'(n_rst_out), 64'(e.nro));
          chk("evt_ready", 64'(ready), 64'(e.rdy));
          chk("evt_run_cnt", 64'(run_cnt), 64'(e.rc));
        end
        prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rel2[6];
    rel2 = '{11, 14, 15, 21, 23, 27};
    n_rst = 1'b1; sw_rst = 1'b0; halt = 1'b0; gap = '0; gap1 = 8'd2;
    #1 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_n_rst_out", 64'(n_rst_out), 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_run_cnt", 64'(run_cnt), 64'h0);
    chk("rst1_n_rst_out", 64'(n_rst_out1), 64'h0);

    // Sequence 1: all gaps 0, then halt freezes run_cnt
    n_rst = 1'b1;
    b = cyc;
    for (int i = 0; i < 6; i++) push(11 + i, 6'((1 << (i + 1)) - 1), (i == 5), 32'd0);
    for (int i = 1; i <= 4; i++) push(16 + i, 6'h3f, 1'b1, 32'(i));
    push(24, 6'h3f, 1'b1, 32'd5);
    push(25, 6'h3f, 1'b1, 32'd6);
    to_edge(5);
    chk("nch1_e5_out", 64'(n_rst_out1), 64'h0);
    chk("nch1_e5_ready", 64'(ready1), 64'h0);
    to_edge(6);
    chk("nch1_e6_out", 64'(n_rst_out1), 64'h1);
    chk("nch1_e6_ready", 64'(ready1), 64'h1);
    chk("nch1_e6_cnt", 64'(run_cnt1), 64'h0);
    to_edge(7);
    chk("nch1_e7_cnt", 64'(run_cnt1), 64'h1);
    to_edge(20);
    chk("nch1_e20_cnt", 64'(run_cnt1), 64'd14);
    halt = 1'b1;
    to_edge(23);
    halt = 1'b0;
    to_edge(25);
    chk("nch1_sat_cnt", 64'(run_cnt1), 64'd15);
    halt = 1'b1;

    // Sequence 2: soft reset from RUN, gaps {0,2,0,5,1,3}, halt ignored outside RUN
    gap = {8'd3, 8'd1, 8'd5, 8'd0, 8'd2, 8'd0};
    push(26, 6'h0, 1'b0, 32'd0);
    sw_rst = 1'b1;
    to_edge(26);
    sw_rst = 1'b0;
    b = cyc;
    for (int i = 0; i < 6; i++) push(rel2[i], 6'((1 << (i + 1)) - 1), (i == 5), 32'd0);
    push(28, 6'h3f, 1'b1, 32'd1);
    push(29, 6'h3f, 1'b1, 32'd2);
    to_edge(27);
    halt = 1'b0;
    to_edge(29);

    // Sequence 3: gap changes after the shadow latch must not matter
    gap = '0;
    push(30, 6'h0, 1'b0, 32'd0);
    sw_rst = 1'b1;
    to_edge(30);
    sw_rst = 1'b0;
    b = cyc;
    push(11, 6'h01, 1'b0, 32'd0);
    push(12, 6'h03, 1'b0, 32'd0);
    to_edge(10);
    gap = {6{8'd7}};
    to_edge(12);

    // Soft reset after domain 1 released; domain 0 re-releases at S+11
    gap = '0;
    push(13, 6'h0, 1'b0, 32'd0);
    sw_rst = 1'b1;
    to_edge(13);
    sw_rst = 1'b0;
    b = cyc;
    for (int i = 0; i < 6; i++) push(11 + i, 6'((1 << (i + 1)) - 1), (i == 5), 32'd0);
    push(17, 6'h3f, 1'b1, 32'd1);
    push(18, 6'h3f, 1'b1, 32'd2);
    to_edge(18);

    // Asynchronous reset between clock edges, after the monitor has sampled edge 18
    #4;
    push(19, 6'h0, 1'b0, 32'd0);
    n_rst = 1'b0;
    #1;
    chk("async_n_rst_out", 64'(n_rst_out), 64'h0);
    chk("async_ready", 64'(ready), 64'h0);
    chk("async_run_cnt", 64'(run_cnt), 64'h0);
    chk("async1_run_cnt", 64'(run_cnt1), 64'h0);
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b1;
    b = cyc;
    for (int i = 0; i < 6; i++) push(11 + i, 6'((1 << (i + 1)) - 1), (i == 5), 32'd0);
    push(17, 6'h3f, 1'b1, 32'd1);
    to_edge(17);
    halt = 1'b1;
    to_edge(20);
    #10;
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
